// File: rtl/ram_fifo_pkg.sv
// Shared constants and types for the RAM-backed FIFO controller.
// Word, address and level widths all follow from RAM_WIDTH and ADDR_SIZE.
package ram_fifo_pkg;

  localparam int RAM_WIDTH = 64;
  localparam int ADDR_SIZE = 12;
  localparam int RAM_DEPTH = 4096;

  typedef logic [RAM_WIDTH-1:0] word_t;
  typedef logic [ADDR_SIZE-1:0] addr_t;
  typedef logic [ADDR_SIZE:0]   level_t;

  // Encodings double as the buffer occupancy count.
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

  localparam level_t FULL_COUNT = level_t'(RAM_DEPTH);

endpackage

// File: rtl/ram_fifo_obuf.sv
// Two-entry output buffer that absorbs the RAM read latency.
// Append and pop may happen in the same cycle; head is always a registered word.
module ram_fifo_obuf
  import ram_fifo_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       append,
  input  word_t      append_data,
  input  logic       pop,
  output logic       valid,
  output word_t      head,
  output logic [1:0] count
);

  buf_state_e state, state_next;
  word_t      head_q, tail_q, head_next, tail_next;

  always_ff @(posedge clock) begin
    if (reset) state <= BUF_EMPTY;
    else       state <= state_next;
  end

  // NOTE: data registers are deliberately not reset; the state alone says which entries hold words.
  always_ff @(posedge clock) begin
    head_q <= head_next;
    tail_q <= tail_next;
  end

  // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
  always_comb begin
    state_next = state;
    head_next  = head_q;
    tail_next  = tail_q;
    case (state)
      BUF_EMPTY: begin
        if (append) begin
          head_next  = append_data;
          state_next = BUF_ONE;
        end
      end
      BUF_ONE: begin
        case ({append, pop})
          2'b10: begin
            tail_next  = append_data;
            state_next = BUF_TWO;
          end
          2'b01:   state_next = BUF_EMPTY;
          2'b11:   head_next  = append_data;
          default: ;
        endcase
      end
      BUF_TWO: begin
        // The issue logic never appends into a full buffer unless a pop frees a slot.
        if (pop) begin
          head_next = tail_q;
          if (append) tail_next  = append_data;
          else        state_next = BUF_ONE;
        end
      end
      default: state_next = BUF_EMPTY;
    endcase
  end

  assign valid = (state != BUF_EMPTY);
  assign head  = head_q;
  assign count = state;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller around an external 1-cycle-latency dual-port RAM.
// Holds pointers, RAM occupancy and read-issue logic; the output buffer hides read latency.
module ram_fifo_ctrl
  import ram_fifo_pkg::*;
(
  input  logic   clock,
  input  logic   reset,
  input  word_t  in_data,
  input  logic   in_valid,
  output logic   in_ready,
  output word_t  out_data,
  output logic   out_valid,
  input  logic   out_ready,
  output level_t level,
  output logic   empty,
  output word_t  ram_data_in,
  output addr_t  ram_wrt_address,
  output logic   ram_write,
  output addr_t  ram_rd_address,
  output logic   ram_read,
  input  word_t  ram_data_out
);

  addr_t      wr_ptr, rd_ptr;
  level_t     ram_count;
  logic       inflight;
  logic [1:0] buf_count;
  logic       buf_valid;
  logic       push, pop, issue;
  logic [2:0] buf_after_pop;

  assign in_ready  = ~reset & (ram_count != FULL_COUNT);
  assign push      = in_valid & in_ready;
  assign out_valid = ~reset & buf_valid;
  assign pop       = out_valid & out_ready;

  // Words the buffer will hold or be owed after this cycle's pop; a read may go out only if one slot stays free.
  assign buf_after_pop = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, pop};
  assign issue         = ~reset & (ram_count != '0) & (buf_after_pop < 3'd2);

  // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ram_count <= '0;
      inflight  <= 1'b0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + addr_t'(1);
      if (issue) rd_ptr <= rd_ptr + addr_t'(1);
      ram_count <= ram_count + level_t'(push) - level_t'(issue);
      inflight  <= issue;
    end
  end

  ram_fifo_obuf u_obuf (
    .clock       (clock),
    .reset       (reset),
    .append      (inflight),
    .append_data (ram_data_out),
    .pop         (pop),
    .valid       (buf_valid),
    .head        (out_data),
    .count       (buf_count)
  );

  assign ram_data_in     = in_data;
  assign ram_wrt_address = wr_ptr;
  assign ram_write       = push;
  assign ram_rd_address  = rd_ptr;
  assign ram_read        = issue;

  assign level = ram_count + level_t'(inflight) + level_t'(buf_count);
  assign empty = (level == '0);

endmodule
